// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the two requester channels, the shared response data and the
// ALU-side signals of alu_share_arbiter.
//   slave  modport : the arbiter (consumes requests, drives the ALU)
//   master modport : requesters plus the ALU (drive requests, ALU results)
// Signals:
//   reqN_valid/ready, reqN_a/b/op : request channel of requester N
//   respN_valid/ready             : response channel of requester N
//   resp_result, resp_zero        : registered ALU result shared by both
//   alu_a, alu_b, alu_ctrl        : ALU operand/control drive
//   alu_result, alu_zero          : combinational ALU outputs
interface alu_share_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [3:0]      req0_op;
    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [3:0]      req1_op;
    logic            resp0_valid;
    logic            resp0_ready;
    logic            resp1_valid;
    logic            resp1_ready;
    logic [XLEN-1:0] resp_result;
    logic            resp_zero;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid,
        input  resp0_ready, resp1_ready,
        output resp_result, resp_zero,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid,
        output resp0_ready, resp1_ready,
        input  resp_result, resp_zero,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares the single 32-bit execute-stage ALU between requester 0 (EX stage)
// and requester 1 (branch/address helper). One operation at a time walks
// IDLE -> EXEC -> RESP; the ALU is driven from latched operands in EXEC and
// the result/zero flag are registered and held until the owner consumes them.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arbiter_if.slave (request/response channels, ALU side)
// Configuration macro ALU_SHARE_ARB_RR_EN:
//   defined   - round-robin between the requesters (priority pointer)
//   undefined - fixed priority, requester 0 always wins
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            owner_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            winner;

`ifdef ALU_SHARE_ARB_RR_EN
    // prio_q names the requester that wins a tie; it flips to the other
    // requester after every accepted request.
    logic prio_q;

    always_comb begin
        grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio_q);
        grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || prio_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~winner;
        end
    end
`else
    always_comb begin
        grant0 = (state_q == IDLE) && bus.req0_valid;
        grant1 = (state_q == IDLE) && bus.req1_valid && !bus.req0_valid;
    end
`endif

    assign accept = grant0 | grant1;
    assign winner = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if ((owner_q == 1'b0 && bus.resp0_ready) ||
                    (owner_q == 1'b1 && bus.resp1_ready)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operation registers: captured on the request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 4'd0;
        end else if (accept) begin
            owner_q <= winner;
            a_q     <= winner ? bus.req1_a  : bus.req0_a;
            b_q     <= winner ? bus.req1_b  : bus.req0_b;
            op_q    <= winner ? bus.req1_op : bus.req0_op;
        end
    end

    // Result registers: loaded only at the end of EXEC so they stay stable
    // for the whole RESP stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            result_q <= bus.alu_result;
            zero_q   <= bus.alu_zero;
        end
    end

    // Ready is combinational from valid; it is also gated by rst_n so a
    // requester holding valid during reset never sees ready.
    always_comb begin
        bus.req0_ready  = grant0 & rst_n;
        bus.req1_ready  = grant1 & rst_n;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_ctrl    = 4'd0;
        if (state_q == EXEC) begin
            bus.alu_a    = a_q;
            bus.alu_b    = b_q;
            bus.alu_ctrl = op_q;
        end
        if (state_q == RESP) begin
            bus.resp0_valid = (owner_q == 1'b0);
            bus.resp1_valid = (owner_q == 1'b1);
        end
    end

    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter. The bench plays both requesters
// and the ALU; expected results are queued at each request handshake and
// compared when the owning response channel presents them.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.XLEN(32)) bus ();

    alu_share_arbiter #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU attached to the arbiter
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = aluModel(bus.alu_a, bus.alu_b, bus.alu_ctrl);
    assign bus.alu_zero   = (bus.alu_result == 32'd0);

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        owner;
        logic [31:0] result;
        logic        zero;
    } sb_t;

    sb_t sb[$];

    typedef struct {
        int          req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveReq(input int k, input logic v, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            bus.req0_valid = v;
            bus.req0_op    = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_op    = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
    endtask

    task automatic setRespReady(input int k, input logic v);
        if (k == 0) bus.resp0_ready = v;
        else        bus.resp1_ready = v;
    endtask

    function automatic logic readyOf(input int k);
        return (k == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic respValidOf(input int k);
        return (k == 0) ? bus.resp0_valid : bus.resp1_valid;
    endfunction

    task automatic pushExpected(input int k, input logic [31:0] res, input logic z);
        sb_t e;
        e.owner  = k[0];
        e.result = res;
        e.zero   = z;
        sb.push_back(e);
    endtask

    // Compare the presented response against the oldest queued expectation
    task automatic popAndCompare();
        sb_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_unexpected_resp", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        checkOutput("resp_owner_valid", 32'(respValidOf(int'(e.owner))), 32'd1);
        checkOutput("resp_other_valid", 32'(respValidOf(1 - int'(e.owner))), 32'd0);
        checkOutput("resp_result", bus.resp_result, e.result);
        checkOutput("resp_zero", 32'(bus.resp_zero), 32'(e.zero));
    endtask

    // Present one request, wait (bounded) for its handshake, then look at
    // the EXEC cycle. Returns at negedge+1 of the EXEC cycle.
    task automatic applyStimulus(input int k, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res,
                                 input logic z, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        driveReq(k, 1'b1, op, a, b);
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (readyOf(k)) ok = 1'b1;
            else @(negedge clk);
        end
        checkOutput("req_accept", 32'(ok), 32'd1);
        if (!ok) begin
            driveReq(k, 1'b0, 4'd0, 32'd0, 32'd0);
            return;
        end
        checkOutput("req_other_ready", 32'(readyOf(1 - k)), 32'd0);
        pushExpected(k, res, z);
        @(negedge clk);
        driveReq(k, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        checkOutput("exec_alu_a", bus.alu_a, a);
        checkOutput("exec_alu_b", bus.alu_b, b);
        checkOutput("exec_alu_ctrl", 32'(bus.alu_ctrl), 32'(op));
        checkOutput("exec_resp_valid", 32'(respValidOf(k)), 32'd0);
    endtask

    // Wait for the response (expected the cycle after EXEC), optionally
    // stall it, then consume it.
    task automatic collectResponse(input int k, input int stall);
        bit seen = 1'b0;
        int waited = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            waited++;
            if (respValidOf(k)) seen = 1'b1;
        end
        checkOutput("resp_seen", 32'(seen), 32'd1);
        if (!seen) begin
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        checkOutput("resp_latency", 32'(waited), 32'd1);
        for (int s = 0; s < stall; s++) begin
            checkOutput("stall_result", bus.resp_result, sb[0].result);
            @(negedge clk);
            #1;
            checkOutput("stall_valid", 32'(respValidOf(k)), 32'd1);
        end
        setRespReady(k, 1'b1);
        #1;
        popAndCompare();
        @(negedge clk);
        setRespReady(k, 1'b0);
        #1;
        checkOutput("resp_valid_drop", 32'(respValidOf(k)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        bit ok;
        int grants;
        int lastGrant;
        int expK;
        int k;

        vecs[0] = '{0, OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1, OP_SUB, 32'h10,         32'h10,         32'd0,          1'b1};
        vecs[2] = '{0, OP_AND, 32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   1'b0};
        vecs[3] = '{1, OP_OR,  32'h0000000F,   32'h000000F0,   32'h000000FF,   1'b0};
        vecs[4] = '{0, OP_XOR, 32'hAAAA5555,   32'hFFFF0000,   32'h55555555,   1'b0};
        vecs[5] = '{1, OP_SLL, 32'd1,          32'd31,         32'h80000000,   1'b0};
        vecs[6] = '{0, OP_SRL, 32'h80000000,   32'd31,         32'd1,          1'b0};
        vecs[7] = '{1, OP_SRA, 32'h80000000,   32'd4,          32'hF8000000,   1'b0};
        vecs[8] = '{0, OP_SUB, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0};
        vecs[9] = '{1, OP_BAD, 32'd3,          32'd4,          32'd0,          1'b1};

        rst_n = 1'b0;
        driveReq(0, 1'b0, 4'd0, 32'd0, 32'd0);
        driveReq(1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        #1;
        checkOutput("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        checkOutput("rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
        checkOutput("rst_resp1_valid", 32'(bus.resp1_valid), 32'd0);
        checkOutput("rst_resp_result", bus.resp_result, 32'd0);
        checkOutput("rst_resp_zero", 32'(bus.resp_zero), 32'd0);
        checkOutput("rst_alu_a", bus.alu_a, 32'd0);
        checkOutput("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single operations on alternating requesters, varied stalls
        for (int i = 0; i < 10; i++) begin
            $display("[TB] vector %0d: req%0d op=%b", i, vecs[i].req, vecs[i].op);
            applyStimulus(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].res, vecs[i].zero, ok);
            if (ok) collectResponse(vecs[i].req, i % 3);
        end

        // Back-pressure: req0 response held for 5 cycles while req1 waits
        $display("[TB] back-pressure sequence");
        applyStimulus(0, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, ok);
        driveReq(1, 1'b1, OP_XOR, 32'd6, 32'd12);
        #1;
        checkOutput("bp_exec_req1_ready", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("bp_resp0_valid", 32'(bus.resp0_valid), 32'd1);
        for (int s = 0; s < 5; s++) begin
            checkOutput("bp_hold_result", bus.resp_result, 32'd5);
            checkOutput("bp_hold_valid", 32'(bus.resp0_valid), 32'd1);
            checkOutput("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        setRespReady(0, 1'b1);
        #1;
        checkOutput("bp_req1_ready_resp", 32'(bus.req1_ready), 32'd0);
        popAndCompare();
        @(negedge clk);
        setRespReady(0, 1'b0);
        #1;
        checkOutput("bp_req1_first_idle", 32'(bus.req1_ready), 32'd1);
        if (bus.req1_ready) begin
            pushExpected(1, 32'd10, 1'b0);
            @(negedge clk);
            driveReq(1, 1'b0, 4'd0, 32'd0, 32'd0);
            #1;
            collectResponse(1, 0);
        end else begin
            driveReq(1, 1'b0, 4'd0, 32'd0, 32'd0);
        end

        // Reset asserted during EXEC drops the operation
        $display("[TB] reset mid-operation");
        applyStimulus(0, OP_ADD, 32'd9, 32'd9, 32'd18, 1'b0, ok);
        driveReq(1, 1'b1, OP_ADD, 32'd1, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_alu_a", bus.alu_a, 32'd0);
        checkOutput("mid_rst_alu_b", bus.alu_b, 32'd0);
        checkOutput("mid_rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        checkOutput("mid_rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
        checkOutput("mid_rst_resp1_valid", 32'(bus.resp1_valid), 32'd0);
        checkOutput("mid_rst_resp_result", bus.resp_result, 32'd0);
        checkOutput("mid_rst_resp_zero", 32'(bus.resp_zero), 32'd0);
        checkOutput("mid_rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        driveReq(1, 1'b0, 4'd0, 32'd0, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_resp0", 32'(bus.resp0_valid), 32'd0);
            checkOutput("post_rst_resp1", 32'(bus.resp1_valid), 32'd0);
        end

        // Contention: both valid every cycle, responses always consumed
        $display("[TB] contention sequence");
        @(negedge clk);
        setRespReady(0, 1'b1);
        setRespReady(1, 1'b1);
        driveReq(0, 1'b1, OP_SLL, 32'd1, 32'd4);
        driveReq(1, 1'b1, OP_SRA, 32'h80000000, 32'd4);
        grants = 0;
        lastGrant = 0;
        for (int cyc = 0; cyc < 40 && (grants < 4 || sb.size() > 0); cyc++) begin
            #1;
            checkOutput("single_grant", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.resp0_valid || bus.resp1_valid) popAndCompare();
            if (bus.req0_ready || bus.req1_ready) begin
                k = bus.req1_ready ? 1 : 0;
`ifdef ALU_SHARE_ARB_RR_EN
                expK = grants % 2;
`else
                expK = 0;
`endif
                checkOutput("grant_order", 32'(k), 32'(expK));
                if (grants > 0) checkOutput("grant_spacing", 32'(cyc - lastGrant), 32'd3);
                lastGrant = cyc;
                if (k == 0) pushExpected(0, 32'h00000010, 1'b0);
                else        pushExpected(1, 32'hF8000000, 1'b0);
                grants++;
            end
            @(negedge clk);
            if (grants == 4) begin
                driveReq(0, 1'b0, 4'd0, 32'd0, 32'd0);
                driveReq(1, 1'b0, 4'd0, 32'd0, 32'd0);
            end
        end
        checkOutput("contention_grants", 32'(grants), 32'd4);
        checkOutput("contention_sb_empty", 32'(sb.size()), 32'd0);
        driveReq(0, 1'b0, 4'd0, 32'd0, 32'd0);
        driveReq(1, 1'b0, 4'd0, 32'd0, 32'd0);
        setRespReady(0, 1'b0);
        setRespReady(1, 1'b0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
